noc_packet_injector: RTL and testbench

- Source-side network interface that turns a command plus a payload stream into one wormhole packet and drives the flit-level `sender_*` handshake into a NoC router local port.
- It is the transmitting end of the link that an endpoint node receives on.
- Each packet is one header flit followed by `len` payload flits, with the tail marked on the last flit.
- It is used at every mesh node that injects traffic: processing elements, DMA engines and bench traffic generators.

---
 rtl/noc_packet_injector.sv | 106 ++++++++++
 tb/tb_noc_packet_injector.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_injector.sv
// Source-side NoC network interface: command + payload stream to wormhole flits.
// One header flit, then len payload flits; tail marked on the last flit.
module noc_packet_injector #(
  parameter int FLIT_W  = 32,
  parameter int COORD_W = 4,
  parameter int LEN_W   = 8,
  parameter int SRC_X   = 0,
  parameter int SRC_Y   = 0
) (
  input  logic               noc_clk,
  input  logic               noc_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_dst_x,
  input  logic [COORD_W-1:0] cmd_dst_y,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               pay_valid,
  output logic               pay_ready,
  input  logic [FLIT_W-1:0]  pay_data,
  output logic               sender_valid,
  input  logic               sender_ready,
  output logic [FLIT_W-1:0]  sender_flit,
  output logic               sender_is_header,
  output logic               sender_is_tail,
  output logic               busy,
  output logic [15:0]        pkt_cnt
);

  localparam int HDR_W = 4 * COORD_W + LEN_W;
  localparam logic [COORD_W-1:0] LP_SX = COORD_W'(SRC_X);
  localparam logic [COORD_W-1:0] LP_SY = COORD_W'(SRC_Y);

  typedef enum logic {
    ST_IDLE,
    ST_BODY
  } state_t;

  state_t             r_state;
  logic [LEN_W-1:0]   r_rem;
  logic [FLIT_W-1:0]  r_flit;
  logic               r_hdr;
  logic               r_tail;
  logic               r_valid;
  logic [15:0]        r_pkt_cnt;

  logic               w_out_free;
  logic               w_cmd_fire;
  logic               w_pay_fire;
  logic               w_last;
  logic [FLIT_W-1:0]  w_hdr;

  assign w_out_free = !r_valid | sender_ready;
  assign cmd_ready  = !noc_rst & (r_state == ST_IDLE) & w_out_free;
  assign pay_ready  = !noc_rst & (r_state == ST_BODY) & w_out_free;
  assign w_cmd_fire = cmd_valid & cmd_ready;
  assign w_pay_fire = pay_valid & pay_ready;
  assign w_last     = (r_rem == LEN_W'(1));

  // Header fields packed from the MSB down; unused LSBs stay zero.
  always_comb begin
    w_hdr = '0;
    w_hdr[FLIT_W-1 -: HDR_W] = {cmd_dst_x, cmd_dst_y, LP_SX, LP_SY, cmd_len};
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      r_state   <= ST_IDLE;
      r_rem     <= '0;
      r_flit    <= '0;
      r_hdr     <= 1'b0;
      r_tail    <= 1'b0;
      r_valid   <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      if (r_valid & sender_ready & r_tail)
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_cmd_fire) begin
        r_flit  <= w_hdr;
        r_hdr   <= 1'b1;
        r_tail  <= (cmd_len == '0);
        r_valid <= 1'b1;
        r_rem   <= cmd_len;
        if (cmd_len != '0)
          r_state <= ST_BODY;
      end else if (w_pay_fire) begin
        r_flit  <= pay_data;
        r_hdr   <= 1'b0;
        r_tail  <= w_last;
        r_valid <= 1'b1;
        r_rem   <= r_rem - LEN_W'(1);
        if (w_last)
          r_state <= ST_IDLE;
      end else if (sender_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign sender_valid     = r_valid;
  assign sender_flit      = r_flit;
  assign sender_is_header = r_hdr;
  assign sender_is_tail   = r_tail;
  assign busy             = (r_state == ST_BODY) | r_valid;
  assign pkt_cnt          = r_pkt_cnt;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector.
// Output bundle = {valid, is_header, is_tail, flit}.
module tb_noc_packet_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  dst_x;
  logic [3:0]  dst_y;
  logic [7:0]  len;
  logic        pay_valid;
  logic        pay_ready;
  logic [31:0] pay_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_flit;
  logic        s_hdr;
  logic        s_tail;
  logic        busy;
  logic [15:0] pkt_cnt;

  int vec = 0;
  int err = 0;
  logic [15:0] exp_pkt = 16'd0;

  always #5 clk = ~clk;

  noc_packet_injector dut (
    .noc_clk          (clk),
    .noc_rst          (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_dst_x        (dst_x),
    .cmd_dst_y        (dst_y),
    .cmd_len          (len),
    .pay_valid        (pay_valid),
    .pay_ready        (pay_ready),
    .pay_data         (pay_data),
    .sender_valid     (s_valid),
    .sender_ready     (s_ready),
    .sender_flit      (s_flit),
    .sender_is_header (s_hdr),
    .sender_is_tail   (s_tail),
    .busy             (busy),
    .pkt_cnt          (pkt_cnt)
  );

  logic [34:0] obs;
  assign obs = {s_valid, s_hdr, s_tail, s_flit};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 0; pay_valid = 0; s_ready = 1;
    dst_x = 0; dst_y = 0; len = 0; pay_data = 0;
    tick(); tick();
    vec++;
    if (obs !== 35'h0) begin
      err++; $display("FAIL reset_out got %h want %h", obs, 35'h0);
    end
    vec++;
    if ({cmd_ready, pay_ready, busy, pkt_cnt} !== 19'h0) begin
      err++; $display("FAIL reset_ctl got %b/%b/%b/%h want 0/0/0/0",
                      cmd_ready, pay_ready, busy, pkt_cnt);
    end
    rst = 1'b0;
    #1;
    vec++;
    if ({cmd_ready, pay_ready} !== 2'b10) begin
      err++; $display("FAIL reset_rdy got %b%b want 10", cmd_ready, pay_ready);
    end
  endtask

  task automatic test_single();
    cmd_valid = 1; dst_x = 1; dst_y = 1; len = 0; s_ready = 1;
    tick();
    cmd_valid = 0;
    #1;
    vec++;
    if (obs !== {3'b111, 32'h1100_0000}) begin
      err++; $display("FAIL single_flit got %h want %h", obs, {3'b111, 32'h1100_0000});
    end
    tick();
    exp_pkt++;
    vec++;
    if ({s_valid, busy, pkt_cnt} !== {2'b00, exp_pkt}) begin
      err++; $display("FAIL single_after got v%b b%b c%0d want v0 b0 c%0d",
                      s_valid, busy, pkt_cnt, exp_pkt);
    end
  endtask

  task automatic test_stream();
    cmd_valid = 1; dst_x = 2; dst_y = 3; len = 3; s_ready = 1;
    pay_valid = 1; pay_data = 32'hA0;
    tick();
    cmd_valid = 0;
    #1;
    vec++;
    if ({obs, pay_ready} !== {3'b110, 32'h2300_0300, 1'b1}) begin
      err++; $display("FAIL stream_hdr got %h rdy %b want %h rdy 1",
                      obs, pay_ready, {3'b110, 32'h2300_0300});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      pay_data = 32'hA1 + i;
      if (i == 2) pay_valid = 0;
      #1;
      vec++;
      if (obs !== {2'b10, (i == 2), 32'hA0 + i}) begin
        err++; $display("FAIL stream_pay%0d got %h want %h", i, obs,
                        {2'b10, (i == 2), 32'hA0 + i});
      end
    end
    tick();
    exp_pkt++;
    vec++;
    if ({s_valid, busy, pkt_cnt} !== {2'b00, exp_pkt}) begin
      err++; $display("FAIL stream_end got v%b b%b c%0d want v0 b0 c%0d",
                      s_valid, busy, pkt_cnt, exp_pkt);
    end
  endtask

  task automatic test_backpressure();
    cmd_valid = 1; dst_x = 2; dst_y = 3; len = 3; s_ready = 1;
    pay_valid = 1; pay_data = 32'hA0;
    tick();
    cmd_valid = 0;
    tick();
    s_ready = 0; pay_data = 32'hA1;
    #1;
    for (int i = 0; i < 4; i++) begin
      vec++;
      if ({obs, pay_ready, cmd_ready} !== {3'b100, 32'hA0, 2'b00}) begin
        err++; $display("FAIL bp_hold%0d got %h pr%b cr%b want %h pr0 cr0",
                        i, obs, pay_ready, cmd_ready, {3'b100, 32'hA0});
      end
      if (i < 3) tick();
    end
    s_ready = 1;
    #1;
    vec++;
    if (pay_ready !== 1'b1) begin
      err++; $display("FAIL bp_release got %b want 1", pay_ready);
    end
    tick();
    pay_data = 32'hA2;
    #1;
    vec++;
    if (obs !== {3'b100, 32'hA1}) begin
      err++; $display("FAIL bp_a1 got %h want %h", obs, {3'b100, 32'hA1});
    end
    tick();
    pay_valid = 0;
    #1;
    vec++;
    if (obs !== {3'b101, 32'hA2}) begin
      err++; $display("FAIL bp_a2 got %h want %h", obs, {3'b101, 32'hA2});
    end
    tick();
    exp_pkt++;
    vec++;
    if ({s_valid, pkt_cnt} !== {1'b0, exp_pkt}) begin
      err++; $display("FAIL bp_end got v%b c%0d want v0 c%0d", s_valid, pkt_cnt, exp_pkt);
    end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1; dst_x = 1; dst_y = 2; len = 1; s_ready = 1;
    pay_valid = 1; pay_data = 32'hB0;
    tick();
    dst_x = 3; dst_y = 1; len = 0;
    #1;
    vec++;
    if ({obs, cmd_ready} !== {3'b110, 32'h1200_0100, 1'b0}) begin
      err++; $display("FAIL b2b_hdr1 got %h cr%b want %h cr0",
                      obs, cmd_ready, {3'b110, 32'h1200_0100});
    end
    tick();
    pay_valid = 0;
    #1;
    vec++;
    if ({obs, cmd_ready} !== {3'b101, 32'hB0, 1'b1}) begin
      err++; $display("FAIL b2b_pay got %h cr%b want %h cr1",
                      obs, cmd_ready, {3'b101, 32'hB0});
    end
    tick();
    cmd_valid = 0;
    exp_pkt++;
    #1;
    vec++;
    if (obs !== {3'b111, 32'h3100_0000}) begin
      err++; $display("FAIL b2b_hdr2 got %h want %h", obs, {3'b111, 32'h3100_0000});
    end
    tick();
    exp_pkt++;
    vec++;
    if ({s_valid, pkt_cnt} !== {1'b0, exp_pkt}) begin
      err++; $display("FAIL b2b_cnt got v%b c%0d want v0 c%0d", s_valid, pkt_cnt, exp_pkt);
    end
  endtask

  task automatic test_starvation();
    cmd_valid = 1; dst_x = 0; dst_y = 1; len = 2; s_ready = 1;
    pay_valid = 0;
    tick();
    cmd_valid = 0;
    #1;
    vec++;
    if (obs !== {3'b110, 32'h0100_0200}) begin
      err++; $display("FAIL starve_hdr got %h want %h", obs, {3'b110, 32'h0100_0200});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vec++;
      if ({s_valid, busy, cmd_ready, pay_ready} !== 4'b0101) begin
        err++; $display("FAIL starve_idle%0d got v%b b%b cr%b pr%b want v0 b1 cr0 pr1",
                        i, s_valid, busy, cmd_ready, pay_ready);
      end
    end
    pay_valid = 1; pay_data = 32'hC0;
    tick();
    pay_data = 32'hC1;
    #1;
    vec++;
    if (obs !== {3'b100, 32'hC0}) begin
      err++; $display("FAIL starve_c0 got %h want %h", obs, {3'b100, 32'hC0});
    end
    tick();
    pay_valid = 0;
    #1;
    vec++;
    if (obs !== {3'b101, 32'hC1}) begin
      err++; $display("FAIL starve_c1 got %h want %h", obs, {3'b101, 32'hC1});
    end
    tick();
    exp_pkt++;
    vec++;
    if ({s_valid, busy, pkt_cnt} !== {2'b00, exp_pkt}) begin
      err++; $display("FAIL starve_end got v%b b%b c%0d want v0 b0 c%0d",
                      s_valid, busy, pkt_cnt, exp_pkt);
    end
  endtask

  task automatic test_max_len();
    int bad = 0;
    cmd_valid = 1; dst_x = 4'hF; dst_y = 4'hE; len = 8'hFF; s_ready = 1;
    pay_valid = 1; pay_data = 32'd0;
    tick();
    cmd_valid = 0;
    #1;
    vec++;
    if (obs !== {3'b110, 32'hFE00_FF00}) begin
      err++; $display("FAIL max_hdr got %h want %h", obs, {3'b110, 32'hFE00_FF00});
    end
    for (int i = 0; i < 255; i++) begin
      tick();
      pay_data = i + 1;
      if (i == 254) pay_valid = 0;
      #1;
      if (obs !== {2'b10, (i == 254), 32'(i)}) bad++;
    end
    vec++;
    if (bad !== 0) begin
      err++; $display("FAIL max_payload got %0d bad flits want 0", bad);
    end
    tick();
    exp_pkt++;
    vec++;
    if ({s_valid, busy, pkt_cnt} !== {2'b00, exp_pkt}) begin
      err++; $display("FAIL max_end got v%b b%b c%0d want v0 b0 c%0d",
                      s_valid, busy, pkt_cnt, exp_pkt);
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1; dst_x = 2; dst_y = 2; len = 4; s_ready = 1;
    pay_valid = 1; pay_data = 32'hD0;
    tick();
    cmd_valid = 0;
    tick();
    rst = 1;
    #1;
    tick();
    exp_pkt = 16'd0;
    vec++;
    if ({obs, busy, pkt_cnt, cmd_ready, pay_ready} !== 54'h0) begin
      err++; $display("FAIL rstmid_out got %h b%b c%0d cr%b pr%b want all 0",
                      obs, busy, pkt_cnt, cmd_ready, pay_ready);
    end
    rst = 0; pay_valid = 0;
    #1;
    vec++;
    if ({cmd_ready, pay_ready} !== 2'b10) begin
      err++; $display("FAIL rstmid_rdy got %b%b want 10", cmd_ready, pay_ready);
    end
    cmd_valid = 1; dst_x = 1; dst_y = 1; len = 0;
    tick();
    cmd_valid = 0;
    #1;
    vec++;
    if (obs !== {3'b111, 32'h1100_0000}) begin
      err++; $display("FAIL rstmid_new got %h want %h", obs, {3'b111, 32'h1100_0000});
    end
    tick();
    exp_pkt++;
    vec++;
    if ({s_valid, pkt_cnt} !== {1'b0, exp_pkt}) begin
      err++; $display("FAIL rstmid_cnt got v%b c%0d want v0 c%0d", s_valid, pkt_cnt, exp_pkt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_starvation();
    test_max_len();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
